rx_mf_slicer: RTL

RX_MF_SLICER -- requirements
Module: rx_mf_slicer

---
 rtl/rx_pkg.sv | 29 ++
 rtl/mf_fir.sv | 84 ++++++++
 rtl/rx_mf_slicer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rx_pkg.sv
// Shared constants, matched-filter taps and control state encoding for the
// rx_mf_slicer receive path.
package rx_pkg;

  localparam int DATA_W         = 8;
  localparam int COEF_W         = 8;
  localparam int NTAPS          = 24;
  localparam int OSR            = 4;
  localparam int SEARCH_SYMS    = 256;
  localparam int SEARCH_STROBES = SEARCH_SYMS * OSR;
  localparam int CNT_W          = $clog2(SEARCH_STROBES);
  localparam int PHASE_W        = $clog2(OSR);
  localparam int PROD_W         = 16;
  localparam int ACC_W          = 17;
  localparam int BIN_W          = 16;
  localparam int FRAC_BITS      = 7;

  localparam logic signed [COEF_W-1:0] COEF [NTAPS] = '{
    8'sd0,  -8'sd2, -8'sd1,  8'sd0,  8'sd2,  8'sd0, -8'sd5, -8'sd11,
    -8'sd7,  8'sd10, 8'sd37, 8'sd62, 8'sd72, 8'sd62, 8'sd37, 8'sd10,
    -8'sd7, -8'sd11, -8'sd5,  8'sd0,  8'sd2,  8'sd0, -8'sd1, -8'sd2
  };

  typedef enum logic {
    SEARCH = 1'b0,
    LOCK   = 1'b1
  } state_t;

endpackage

// File: rtl/mf_fir.sv
// Matched filter: 24-tap FIR over the enabled-sample delay line in three
// registered stages, with a strobe that follows each accepted sample.
module mf_fir
  import rx_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] i_sample,
  output logic signed [DATA_W-1:0] o_filt,
  output logic                     o_vld
);

  localparam int SH_W = ACC_W - FRAC_BITS;
  localparam logic signed [SH_W-1:0] SAT_MAX = SH_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [SH_W-1:0] SAT_MIN = SH_W'(-(1 << (DATA_W - 1)));

  function automatic logic signed [DATA_W-1:0] shift_sat(input logic signed [ACC_W-1:0] acc_in);
    logic signed [SH_W-1:0] sh;
    sh = acc_in[ACC_W-1:FRAC_BITS];
    if (sh > SAT_MAX) return SAT_MAX[DATA_W-1:0];
    if (sh < SAT_MIN) return SAT_MIN[DATA_W-1:0];
    return sh[DATA_W-1:0];
  endfunction

  logic signed [DATA_W-1:0] dly_p0_d [NTAPS];
  logic signed [DATA_W-1:0] dly_p0_q [NTAPS];
  logic                     vld_p0_d, vld_p0_q;
  logic signed [PROD_W-1:0] prod_p1_d [NTAPS];
  logic signed [PROD_W-1:0] prod_p1_q [NTAPS];
  logic                     vld_p1_d, vld_p1_q;
  logic signed [ACC_W-1:0]  acc_p1;
  logic signed [DATA_W-1:0] filt_p2_d, filt_p2_q;
  logic                     vld_p2_d, vld_p2_q;

  // p0: delay line, advances only on accepted samples
  always_comb begin
    dly_p0_d = dly_p0_q;
    vld_p0_d = enable;
    if (enable) begin
      dly_p0_d[0] = i_sample;
      for (int k = 1; k < NTAPS; k++) dly_p0_d[k] = dly_p0_q[k-1];
    end
  end

  // p1: one registered product per tap
  always_comb begin
    vld_p1_d = vld_p0_q;
    for (int k = 0; k < NTAPS; k++)
      prod_p1_d[k] = PROD_W'(dly_p0_q[k]) * PROD_W'(COEF[k]);
  end

  // p2: sum of products, scaled back to S(8,7) and clamped
  always_comb begin
    acc_p1 = '0;
    for (int k = 0; k < NTAPS; k++) acc_p1 = acc_p1 + ACC_W'(prod_p1_q[k]);
    filt_p2_d = shift_sat(acc_p1);
    vld_p2_d  = vld_p1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NTAPS; k++) begin
        dly_p0_q[k]  <= '0;
        prod_p1_q[k] <= '0;
      end
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      filt_p2_q <= '0;
      vld_p2_q  <= 1'b0;
    end else begin
      dly_p0_q  <= dly_p0_d;
      vld_p0_q  <= vld_p0_d;
      prod_p1_q <= prod_p1_d;
      vld_p1_q  <= vld_p1_d;
      filt_p2_q <= filt_p2_d;
      vld_p2_q  <= vld_p2_d;
    end
  end

  assign o_filt = filt_p2_q;
  assign o_vld  = vld_p2_q;

endmodule

// File: rtl/rx_mf_slicer.sv
// Receive matched filter with energy-based decimation phase search and a
// sign slicer that emits one decision per symbol once locked.
module rx_mf_slicer
  import rx_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic signed [DATA_W-1:0] i_rx,
  input  logic                     i_resync,
  output logic signed [DATA_W-1:0] o_filt,
  output logic                     o_rx,
  output logic                     o_valid,
  output logic                     o_lock,
  output logic [PHASE_W-1:0]       o_phase
);

  logic signed [DATA_W-1:0] filt;
  logic                     strobe;

  mf_fir u_mf_fir (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .i_sample (i_rx),
    .o_filt   (filt),
    .o_vld    (strobe)
  );

  state_t             state_q, state_d;
  logic [PHASE_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] best_phase;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIN_W-1:0]   bin_q [OSR];
  logic [BIN_W-1:0]   bin_d [OSR];
  logic [BIN_W-1:0]   bin_acc [OSR];
  logic               valid_q, valid_d;
  logic               rx_q, rx_d;

  // |x| on DATA_W-1 bits; the most negative code has no positive twin and maps to full scale
  function automatic logic [DATA_W-2:0] mag_sat(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] n;
    if (!x[DATA_W-1]) return x[DATA_W-2:0];
    n = -x;
    if (n[DATA_W-1]) return '1;
    return n[DATA_W-2:0];
  endfunction

  always_comb begin
    bin_acc = bin_q;
    bin_acc[phase_cnt_q] = bin_q[phase_cnt_q] + BIN_W'(mag_sat(filt));
    best_phase = '0;
    for (int i = 1; i < OSR; i++)
      if (bin_acc[i] > bin_acc[best_phase]) best_phase = PHASE_W'(i);
  end

  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    valid_d     = 1'b0;
    rx_d        = rx_q;

    if (strobe) phase_cnt_d = phase_cnt_q + 1'b1;

    case (state_q)
      SEARCH: begin
        if (strobe) begin
          bin_d = bin_acc;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(SEARCH_STROBES - 1)) begin
            phase_d = best_phase;
            state_d = LOCK;
            cnt_d   = '0;
            for (int i = 0; i < OSR; i++) bin_d[i] = '0;
          end
        end
      end
      LOCK: begin
        if (strobe && (phase_cnt_q == phase_q)) begin
          valid_d = 1'b1;
          rx_d    = ~filt[DATA_W-1];
        end
      end
      default: state_d = SEARCH;
    endcase

    // Re-acquisition wins over a search that completes in the same cycle
    if (i_resync) begin
      state_d = SEARCH;
      phase_d = phase_q;
      cnt_d   = '0;
      valid_d = 1'b0;
      rx_d    = rx_q;
      for (int i = 0; i < OSR; i++) bin_d[i] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEARCH;
      phase_cnt_q <= '0;
      phase_q     <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < OSR; i++) bin_q[i] <= '0;
      valid_q     <= 1'b0;
      rx_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      valid_q     <= valid_d;
      rx_q        <= rx_d;
    end
  end

  assign o_filt  = filt;
  assign o_rx    = rx_q;
  assign o_valid = valid_q;
  assign o_lock  = (state_q == LOCK);
  assign o_phase = phase_q;

endmodule
